ibex_csr_access_ctrl: RTL

- Sequencer directly upstream of a bank of ibex_csr register primitives.
- Accepts single CSR access requests (read, write, set, clear) over a valid/ready handshake.
- Performs the read-modify-write and drives each primitive's wr_en_i/wr_data_i.
- Collects rd_data_o/rd_error_o from the bank, returns a response, and raises a sticky alert on any shadow-copy mismatch.

---
 rtl/ibex_csr_access_pkg.sv | 24 ++
 rtl/ibex_csr_access_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ibex_csr_access_pkg.sv
// rtl/ibex_csr_access_pkg.sv - shared types for the CSR access sequencer
// (VERIFY state present only with IBEX_CSR_ACCESS_WRITE_VERIFY_EN).
package ibex_csr_access_pkg;

  localparam int CSR_OP_W = 2;

  typedef enum logic [CSR_OP_W-1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
`ifdef IBEX_CSR_ACCESS_WRITE_VERIFY_EN
    ST_VERIFY,
`endif
    ST_RESP
  } csr_acc_state_e;

endpackage

// File: rtl/ibex_csr_access_ctrl.sv
// rtl/ibex_csr_access_ctrl.sv - read-modify-write sequencer in front of a bank of ibex_csr
// primitives; IBEX_CSR_ACCESS_WRITE_VERIFY_EN adds a read-back check after each write.
module ibex_csr_access_ctrl
  import ibex_csr_access_pkg::*;
#(
  parameter int NumCsr = 8,
  parameter int Width  = 32,
  parameter int AddrW  = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrW-1:0]        req_addr_i,
  input  logic [CSR_OP_W-1:0]     req_op_i,
  input  logic [Width-1:0]        req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [Width-1:0]        rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic [NumCsr-1:0]       csr_wr_en_o,
  output logic [Width-1:0]        csr_wr_data_o,
  input  logic [NumCsr*Width-1:0] csr_rd_data_i,
  input  logic [NumCsr-1:0]       csr_rd_error_i,
  output logic                    alert_o,
  input  logic                    alert_clr_i
);

  csr_acc_state_e   state_q, state_d;
  logic [AddrW-1:0] addr_q;
  csr_op_e          op_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] old_q;
  logic             err_q;
  logic [Width-1:0] wr_data_q;
  logic             alert_q;

  logic [Width-1:0]  sel_data;
  logic              sel_err;
  logic              sel_hit;
  logic [NumCsr-1:0] sel_onehot;
  logic [Width-1:0]  rd_old;
  logic              rd_err;
  logic [Width-1:0]  new_val;
  logic              do_write;
  logic              verify_fail;
  logic              alert_set;

  // Out-of-range addresses match no primitive and read back as an erroring zero.
  always_comb begin
    sel_data   = '0;
    sel_err    = 1'b0;
    sel_hit    = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NumCsr; i++) begin
      if (addr_q == AddrW'(i)) begin
        sel_data      = csr_rd_data_i[i*Width +: Width];
        sel_err       = csr_rd_error_i[i];
        sel_hit       = 1'b1;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign rd_old = sel_hit ? sel_data : '0;
  assign rd_err = ~sel_hit | sel_err;

  always_comb begin
    new_val = rd_old;
    unique case (op_q)
      CSR_OP_WRITE: new_val = wdata_q;
      CSR_OP_SET:   new_val = rd_old | wdata_q;
      CSR_OP_CLEAR: new_val = rd_old & ~wdata_q;
      default:      new_val = rd_old;
    endcase
  end

  // A SET/CLEAR with an empty mask cannot change the CSR, so the write is skipped.
  assign do_write = (op_q != CSR_OP_READ) & ~rd_err &
                    ~(((op_q == CSR_OP_SET) | (op_q == CSR_OP_CLEAR)) & (wdata_q == '0));

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_error_o = 1'b0;
    csr_wr_en_o = '0;
    verify_fail = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_READ;
      end
      ST_READ: state_d = do_write ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        csr_wr_en_o = sel_onehot;
`ifdef IBEX_CSR_ACCESS_WRITE_VERIFY_EN
        state_d = ST_VERIFY;
`else
        state_d = ST_RESP;
`endif
      end
`ifdef IBEX_CSR_ACCESS_WRITE_VERIFY_EN
      ST_VERIFY: begin
        verify_fail = sel_err | (sel_data != wr_data_q);
        state_d     = ST_RESP;
      end
`endif
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = old_q;
        rsp_error_o = err_q;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alert_set = (|csr_rd_error_i) | verify_fail;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= CSR_OP_READ;
      wdata_q   <= '0;
      old_q     <= '0;
      err_q     <= 1'b0;
      wr_data_q <= '0;
      alert_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alert_q <= alert_set | (alert_q & ~alert_clr_i);
      if (state_q == ST_IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        op_q    <= csr_op_e'(req_op_i);
        wdata_q <= req_wdata_i;
      end
      if (state_q == ST_READ) begin
        old_q <= rd_old;
        err_q <= rd_err;
        if (do_write) wr_data_q <= new_val;
      end
      if (verify_fail) err_q <= 1'b1;
    end
  end

  assign csr_wr_data_o = wr_data_q;
  assign alert_o       = alert_q;

endmodule
